fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Parametrised instruction-fetch front end for the RISC-V pipeline. Replaces the single-entry held-instruction scheme in the IF stage.
- Issues sequential fetch requests to instruction memory over a valid/ready interface and tolerates variable memory latency.
- Buffers returned words in a DEPTH-entry queue and presents {pc, instr} to the IF/ID register with a valid/ready stall handshake.
- Redirects (branch/jump) flush all buffered and in-flight fetches cleanly.

Parameters:
XLEN, 32, address/instruction width
DEPTH, 4, queue entries (power of two, >=2)
MAX_OUTSTANDING, 2, maximum accepted-but-unanswered memory requests (1..DEPTH)
INITIAL_PC, 32'h0000_0000, fetch PC after reset

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
redirect_valid  in  1  flush and restart fetch at redirect_pc
redirect_pc  in  XLEN  new fetch address; bits [1:0] ignored (treated as 0)
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  word-aligned fetch address
imem_resp_valid  in  1  response data valid (in order, one per accepted request)
imem_resp_data  in  XLEN  instruction word
out_valid  out  1  queue head valid
out_ready  in  1  IF/ID accepts head (0 = pipeline stall)
out_pc  out  XLEN  PC of head instruction
out_instr  out  XLEN  head instruction
outstanding  out  $clog2(MAX_OUTSTANDING+1)  live in-flight count (debug/verification)

Behaviour:
- Reset: one clock; reset is synchronous and active-high (sampled at posedge clock).
  - Reset state: fetch_pc=INITIAL_PC, queue empty, outstanding=0, discard=0.
  - Outputs: imem_req_valid=0, out_valid=0, out_pc=0, out_instr=0.
  - Reset mid-operation aborts everything. Responses arriving after reset for pre-reset requests are the memory's responsibility; memory is reset together with this block.
- Request issue:
  - imem_req_valid = !redirect_valid && (count + outstanding + discard < DEPTH) && (outstanding + discard < MAX_OUTSTANDING).
  - imem_req_addr = fetch_pc. On a handshake (valid && ready), fetch_pc += 4, wrapping modulo 2^XLEN.
  - imem_req_addr is held stable while valid && !ready.
- Tags: the queue records the PC of every accepted request in a small in-order PC FIFO of depth MAX_OUTSTANDING. A response pairs with the oldest recorded PC.
- Response (no redirect):
  - If discard>0: drop the word and decrement discard.
  - Otherwise: push {pc, data} into the queue and decrement outstanding.
  - Credit accounting guarantees the queue never overflows. Overflow is an assertion failure.
- Output:
  - Head is registered; out_valid = (count>0).
  - Latency: a response at cycle N appears at out_* in cycle N+1 at the earliest. There is no combinational resp-to-out path.
  - Pop on out_valid && out_ready.
  - Simultaneous push and pop are permitted at any occupancy, including full with pop.
- Redirect (highest priority):
  - Queue is cleared (count=0, out_valid=0 next cycle). fetch_pc = {redirect_pc[XLEN-1:2], 2'b00}.
  - discard += outstanding, outstanding = 0. If imem_resp_valid arrives in the same cycle, that word is dropped and counted against the total.
  - imem_req_valid is forced 0 in the redirect cycle. The first request at the new PC is issued the next cycle at the earliest.
  - A pop in the redirect cycle is still honoured (the consumer saw the old head).
  - Back-to-back redirects: the last one wins; discard keeps accumulating correctly.
- Counters: count width $clog2(DEPTH+1). outstanding+discard never exceeds MAX_OUTSTANDING. Underflow (response with nothing in flight) is an assertion failure.
- Stall: out_ready=0 holds the head; fetching continues until credits are exhausted.

Test Plan:
- Reset then free run, 1-cycle memory, out_ready=1 -> out_pc sequence 0x0,0x4,0x8,... with no gaps after 2-cycle startup; outstanding<=MAX_OUTSTANDING.
- out_ready=0 for 20 cycles, DEPTH=4 -> exactly 4 entries buffered (PC 0x0..0xC), imem_req_valid=0 after credits exhausted. Release -> 0x0,0x4,0x8,0xC,0x10 in order, no loss or duplication.
- Memory latency 3, MAX_OUTSTANDING=2, redirect to 0x103 while 2 requests are in flight -> both old responses dropped, next out_pc=0x100 with the word at 0x100, queue empty in between.
- Redirect in the same cycle as imem_resp_valid and out_ready=1 with head valid -> old head popped once, response dropped, discard ends 0 after remaining old responses.
- imem_req_ready low for 5 cycles -> imem_req_addr held constant, no fetch_pc advance. Back-to-back redirects to 0x200 then 0x300 -> only 0x300 stream is delivered.
- Fetch wrap: INITIAL_PC=0xFFFF_FFF8 -> out_pc 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000. Synchronous reset asserted mid-burst -> next cycle out_valid=0, imem_req_valid=0, restart at INITIAL_PC.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Handshake bundle between the fetch queue, instruction memory and the IF/ID register.
// master = fetch queue side, slave = memory/pipeline side.
interface fetch_queue_if #(
  parameter int unsigned XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [XLEN-1:0] imem_resp_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;

  modport master (
    output imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr,
    output imem_req_ready, imem_resp_valid, imem_resp_data, out_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: credit-limited sequential fetch, in-order PC tagging of
// in-flight requests, DEPTH-entry {pc, instr} queue, and redirect flush with discard counting.
module fetch_queue #(
  parameter int unsigned     XLEN            = 32,
  parameter int unsigned     DEPTH           = 4,
  parameter int unsigned     MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] INITIAL_PC      = {XLEN{1'b0}}
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 redirect_valid,
  input  logic [XLEN-1:0]                      redirect_pc,
  fetch_queue_if.master                        bus,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned SW = $clog2(DEPTH + MAX_OUTSTANDING + 1);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(32'd3));

  logic [XLEN-1:0] fetch_pc_r;
  logic            run_r;
  logic [CW-1:0]   count_r, count_n_s;
  logic [OW-1:0]   outstanding_r, outstanding_n_s;
  logic [OW-1:0]   discard_r, discard_n_s;
  logic [AW-1:0]   rd_ptr_r, wr_ptr_r;
  logic [XLEN-1:0] q_pc_r    [DEPTH];
  logic [XLEN-1:0] q_instr_r [DEPTH];
  logic [XLEN-1:0] tag_r     [MAX_OUTSTANDING];
  logic [TW-1:0]   tag_rd_r, tag_wr_r;

  logic [SW-1:0]   inflight_s;
  logic            credit_ok_s;
  logic            req_valid_s;
  logic            req_fire_s;
  logic            resp_drop_s;
  logic            push_s;
  logic            pop_s;

  function automatic logic [TW-1:0] tag_next(input logic [TW-1:0] p);
    if (p == TW'(MAX_OUTSTANDING - 1)) begin
      tag_next = {TW{1'b0}};
    end else begin
      tag_next = p + TW'(1'b1);
    end
  endfunction

  // Credit check and handshake decode; requests stall while a redirect is presented.
  always_comb begin
    inflight_s  = SW'(outstanding_r) + SW'(discard_r);
    credit_ok_s = ((SW'(count_r) + inflight_s) < SW'(DEPTH)) &&
                  (inflight_s < SW'(MAX_OUTSTANDING));
    req_valid_s = run_r && !redirect_valid && credit_ok_s;
    req_fire_s  = req_valid_s && bus.imem_req_ready;
    resp_drop_s = bus.imem_resp_valid && (redirect_valid || (discard_r != {OW{1'b0}}));
    push_s      = bus.imem_resp_valid && !resp_drop_s;
    pop_s       = (count_r != {CW{1'b0}}) && bus.out_ready;
  end

  // Occupancy and in-flight accounting; a redirect converts live requests into discards.
  always_comb begin
    count_n_s       = count_r;
    outstanding_n_s = outstanding_r;
    discard_n_s     = discard_r;
    if (redirect_valid) begin
      count_n_s       = {CW{1'b0}};
      outstanding_n_s = {OW{1'b0}};
      discard_n_s     = discard_r + outstanding_r - OW'(bus.imem_resp_valid);
    end else if (bus.imem_resp_valid && (discard_r != {OW{1'b0}})) begin
      count_n_s       = count_r - CW'(pop_s);
      outstanding_n_s = outstanding_r + OW'(req_fire_s);
      discard_n_s     = discard_r - OW'(1'b1);
    end else begin
      count_n_s       = count_r + CW'(push_s) - CW'(pop_s);
      outstanding_n_s = outstanding_r + OW'(req_fire_s) - OW'(push_s);
      discard_n_s     = discard_r;
    end
  end

  // State registers: fetch PC, tag FIFO, data queue and counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_r    <= INITIAL_PC;
      run_r         <= 1'b0;
      count_r       <= {CW{1'b0}};
      outstanding_r <= {OW{1'b0}};
      discard_r     <= {OW{1'b0}};
      rd_ptr_r      <= {AW{1'b0}};
      wr_ptr_r      <= {AW{1'b0}};
      tag_rd_r      <= {TW{1'b0}};
      tag_wr_r      <= {TW{1'b0}};
      for (int i = 0; i < int'(DEPTH); i++) begin
        q_pc_r[i]    <= {XLEN{1'b0}};
        q_instr_r[i] <= {XLEN{1'b0}};
      end
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
        tag_r[i] <= {XLEN{1'b0}};
      end
    end else begin
      run_r         <= 1'b1;
      count_r       <= count_n_s;
      outstanding_r <= outstanding_n_s;
      discard_r     <= discard_n_s;
      if (redirect_valid) begin
        fetch_pc_r <= redirect_pc & ALIGN_MASK;
        rd_ptr_r   <= {AW{1'b0}};
        wr_ptr_r   <= {AW{1'b0}};
        // Tags of flushed requests are never consumed: their responses take the discard path.
        tag_rd_r   <= {TW{1'b0}};
        tag_wr_r   <= {TW{1'b0}};
      end else begin
        if (req_fire_s) begin
          fetch_pc_r      <= fetch_pc_r + XLEN'(32'd4);
          tag_r[tag_wr_r] <= fetch_pc_r;
          tag_wr_r        <= tag_next(tag_wr_r);
        end
        if (push_s) begin
          q_pc_r[wr_ptr_r]    <= tag_r[tag_rd_r];
          q_instr_r[wr_ptr_r] <= bus.imem_resp_data;
          wr_ptr_r            <= wr_ptr_r + AW'(1'b1);
          tag_rd_r            <= tag_next(tag_rd_r);
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + AW'(1'b1);
        end
      end
    end
  end

  assign bus.imem_req_valid = req_valid_s;
  assign bus.imem_req_addr  = fetch_pc_r;
  assign bus.out_valid      = (count_r != {CW{1'b0}});
  assign bus.out_pc         = q_pc_r[rd_ptr_r];
  assign bus.out_instr      = q_instr_r[rd_ptr_r];
  assign outstanding        = outstanding_r;
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: variable-latency memory model plus an output scoreboard.
module tb_fetch_queue;
  localparam logic [31:0] INIT_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  logic        clock;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [1:0]  outstanding;

  fetch_queue_if #(.XLEN(32)) bus ();

  fetch_queue #(
    .XLEN(32), .DEPTH(4), .MAX_OUTSTANDING(2), .INITIAL_PC(INIT_PC)
  ) dut (
    .clock(clock),
    .reset(reset),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .bus(bus),
    .outstanding(outstanding)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          lat      = 1;
  int          gap_cnt  = 0;
  bit          mem_ready, cons_ready, seen_valid;
  bit          last_rv, last_pop, last_req_valid, last_out_valid;
  logic [31:0] last_addr, last_out_pc, exp_req_pc;
  mreq_t       mem_q[$];
  logic [63:0] exp_q[$];
  logic [31:0] got_q[$];

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // One clock: drive memory/consumer/redirect, sample at negedge, score, then cross posedge.
  task automatic tick(input logic redir, input logic [31:0] rpc);
    logic [63:0] exp_e;
    @(negedge clock);
    redirect_valid     = redir;
    redirect_pc        = rpc;
    bus.imem_req_ready = mem_ready;
    bus.out_ready      = cons_ready;
    last_rv            = 1'b0;
    bus.imem_resp_data = 32'h0;
    if (mem_q.size() > 0) begin
      if (mem_q[0].due <= cyc) begin
        last_rv            = 1'b1;
        bus.imem_resp_data = word_at(mem_q[0].addr);
      end
    end
    bus.imem_resp_valid = last_rv;
    #1;
    last_req_valid = bus.imem_req_valid;
    last_addr      = bus.imem_req_addr;
    last_out_valid = bus.out_valid;
    last_out_pc    = bus.out_pc;
    n_checks++;
    if (outstanding > 2'd2) begin
      n_fail++;
      $display("FAIL outstanding_limit: got %0d max 2", outstanding);
    end
    if (redir) begin
      n_checks++;
      if (last_req_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL req_in_redirect: imem_req_valid %b expected 0", last_req_valid);
      end
    end
    if (last_req_valid && mem_ready) begin
      n_checks++;
      if (last_addr !== exp_req_pc) begin
        n_fail++;
        $display("FAIL req_addr: got %h expected %h", last_addr, exp_req_pc);
      end
      mem_q.push_back('{last_addr, cyc + lat});
      exp_q.push_back({exp_req_pc, word_at(exp_req_pc)});
      exp_req_pc = exp_req_pc + 32'd4;
    end
    if (last_rv) void'(mem_q.pop_front());
    last_pop = last_out_valid && cons_ready;
    if (last_pop) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_out: got pc %h with nothing expected", bus.out_pc);
      end else begin
        exp_e = exp_q.pop_front();
        if ({bus.out_pc, bus.out_instr} !== exp_e) begin
          n_fail++;
          $display("FAIL out_entry: got %h/%h expected %h/%h",
                   bus.out_pc, bus.out_instr, exp_e[63:32], exp_e[31:0]);
        end
      end
      got_q.push_back(bus.out_pc);
    end
    if (seen_valid && !last_out_valid) gap_cnt++;
    if (last_out_valid) seen_valid = 1'b1;
    if (redir) begin
      exp_q.delete();
      exp_req_pc = {rpc[31:2], 2'b00};
    end
    @(posedge clock);
    cyc++;
  endtask

  // Reset asserted across one posedge; returns at the following negedge with reset still high.
  task automatic do_reset();
    @(negedge clock);
    reset               = 1'b1;
    redirect_valid      = 1'b0;
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.out_ready       = 1'b0;
    @(posedge clock);
    cyc++;
    mem_q.delete();
    exp_q.delete();
    got_q.delete();
    exp_req_pc = INIT_PC;
    seen_valid = 1'b0;
    gap_cnt    = 0;
    @(negedge clock);
  endtask

  task automatic run_until_got(input int n, input int budget);
    int k = 0;
    while (got_q.size() < n && k < budget) begin
      tick(1'b0, 32'h0);
      k++;
    end
    n_checks++;
    if (got_q.size() < n) begin
      n_fail++;
      $display("FAIL timeout: got %0d outputs expected %0d", got_q.size(), n);
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    n_checks++;
    if (bus.imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b expected 0", bus.imem_req_valid); end
    n_checks++;
    if (bus.out_pc !== 32'h0) begin n_fail++; $display("FAIL reset_out_pc: got %h expected 0", bus.out_pc); end
    n_checks++;
    if (bus.out_instr !== 32'h0) begin n_fail++; $display("FAIL reset_out_instr: got %h expected 0", bus.out_instr); end
    n_checks++;
    if (outstanding !== 2'd0) begin n_fail++; $display("FAIL reset_outstanding: got %0d expected 0", outstanding); end
    n_checks++;
    if (bus.imem_req_addr !== INIT_PC) begin n_fail++; $display("FAIL reset_req_addr: got %h expected %h", bus.imem_req_addr, INIT_PC); end
    reset = 1'b0;
  endtask

  task automatic test_free_run();
    lat = 1; mem_ready = 1'b1; cons_ready = 1'b1;
    run_until_got(20, 60);
    for (int i = 0; i < 20 && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== 32'(4 * i)) begin
        n_fail++;
        $display("FAIL free_run_pc[%0d]: got %h expected %h", i, got_q[i], 32'(4 * i));
      end
    end
    n_checks++;
    if (gap_cnt != 0) begin n_fail++; $display("FAIL free_run_gaps: got %0d expected 0", gap_cnt); end
  endtask

  task automatic test_stall();
    logic [31:0] exp_pc [5] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    do_reset(); reset = 1'b0;
    lat = 1; mem_ready = 1'b1; cons_ready = 1'b0;
    repeat (20) tick(1'b0, 32'h0);
    n_checks++;
    if (exp_q.size() != 4) begin n_fail++; $display("FAIL stall_buffered: got %0d expected 4", exp_q.size()); end
    n_checks++;
    if (last_req_valid !== 1'b0) begin n_fail++; $display("FAIL stall_req_valid: got %b expected 0", last_req_valid); end
    n_checks++;
    if (last_out_valid !== 1'b1 || last_out_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL stall_head: got valid %b pc %h expected 1 / 0", last_out_valid, last_out_pc);
    end
    cons_ready = 1'b1;
    run_until_got(5, 30);
    for (int i = 0; i < 5 && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_pc[i]) begin n_fail++; $display("FAIL stall_release[%0d]: got %h expected %h", i, got_q[i], exp_pc[i]); end
    end
  endtask

  task automatic test_redirect_latency();
    bit found = 1'b0;
    do_reset(); reset = 1'b0;
    lat = 3; mem_ready = 1'b1; cons_ready = 1'b1;
    for (int k = 0; k < 20 && !found; k++) begin
      tick(1'b0, 32'h0);
      #1;
      if (outstanding == 2'd2) found = 1'b1;
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL redir_lat_setup: outstanding never reached 2"); end
    got_q.delete();
    tick(1'b1, 32'h103);
    #1;
    n_checks++;
    if (outstanding !== 2'd0) begin n_fail++; $display("FAIL redir_lat_outstanding: got %0d expected 0", outstanding); end
    tick(1'b0, 32'h0);
    n_checks++;
    if (last_out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_lat_empty: got %b expected 0", last_out_valid); end
    run_until_got(2, 40);
    n_checks++;
    if (got_q.size() < 2 || got_q[0] !== 32'h100 || got_q[1] !== 32'h104) begin
      n_fail++;
      $display("FAIL redir_lat_stream: got %h expected 100 then 104", (got_q.size() > 0) ? got_q[0] : 32'hX);
    end
    lat = 1;
  endtask

  task automatic test_redirect_same_cycle();
    do_reset(); reset = 1'b0;
    lat = 1; mem_ready = 1'b1; cons_ready = 1'b1;
    run_until_got(4, 20);
    tick(1'b1, 32'h80);
    n_checks++;
    if (!(last_rv && last_pop)) begin n_fail++; $display("FAIL same_cycle_setup: resp %b pop %b expected 1 1", last_rv, last_pop); end
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL same_cycle_flush: out_valid %b expected 0", bus.out_valid); end
    got_q.delete();
    run_until_got(3, 20);
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== 32'h80 + 32'(4 * i)) begin
        n_fail++;
        $display("FAIL same_cycle_stream[%0d]: got %h expected %h", i, got_q[i], 32'h80 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_req_hold();
    logic [31:0] hold_pc;
    do_reset(); reset = 1'b0;
    lat = 1; mem_ready = 1'b1; cons_ready = 1'b1;
    run_until_got(2, 20);
    mem_ready = 1'b0;
    hold_pc   = exp_req_pc;
    repeat (5) begin
      tick(1'b0, 32'h0);
      n_checks++;
      if (last_req_valid !== 1'b1 || last_addr !== hold_pc) begin
        n_fail++;
        $display("FAIL req_hold: got valid %b addr %h expected 1 / %h", last_req_valid, last_addr, hold_pc);
      end
    end
    mem_ready = 1'b1;
    got_q.delete();
    run_until_got(4, 20);
  endtask

  task automatic test_back_to_back();
    do_reset(); reset = 1'b0;
    lat = 3; mem_ready = 1'b1; cons_ready = 1'b1;
    run_until_got(2, 30);
    tick(1'b1, 32'h200);
    tick(1'b1, 32'h300);
    got_q.delete();
    run_until_got(3, 60);
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== 32'h300 + 32'(4 * i)) begin
        n_fail++;
        $display("FAIL b2b_stream[%0d]: got %h expected %h", i, got_q[i], 32'h300 + 32'(4 * i));
      end
    end
    lat = 1;
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
    lat = 1; mem_ready = 1'b1; cons_ready = 1'b1;
    run_until_got(1, 20);
    tick(1'b1, 32'hFFFF_FFF8);
    got_q.delete();
    run_until_got(4, 20);
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_pc[i]) begin n_fail++; $display("FAIL wrap[%0d]: got %h expected %h", i, got_q[i], exp_pc[i]); end
    end
  endtask

  task automatic test_reset_mid();
    lat = 1; mem_ready = 1'b1; cons_ready = 1'b1;
    got_q.delete();
    run_until_got(3, 20);
    do_reset();
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.imem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: out_valid %b req_valid %b expected 0 0", bus.out_valid, bus.imem_req_valid);
    end
    n_checks++;
    if (outstanding !== 2'd0 || bus.imem_req_addr !== INIT_PC) begin
      n_fail++;
      $display("FAIL reset_mid_state: outstanding %0d addr %h expected 0 / %h", outstanding, bus.imem_req_addr, INIT_PC);
    end
    reset = 1'b0;
    run_until_got(3, 20);
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== INIT_PC + 32'(4 * i)) begin
        n_fail++;
        $display("FAIL reset_mid_restart[%0d]: got %h expected %h", i, got_q[i], INIT_PC + 32'(4 * i));
      end
    end
  endtask

  initial begin
    reset               = 1'b1;
    redirect_valid      = 1'b0;
    redirect_pc         = 32'h0;
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = 32'h0;
    bus.out_ready       = 1'b0;
    mem_ready           = 1'b1;
    cons_ready          = 1'b1;
    exp_req_pc          = INIT_PC;
    test_reset();
    test_free_run();
    test_stall();
    test_redirect_latency();
    test_redirect_same_cycle();
    test_req_hold();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
